// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/sequencing
// controller. The controller sits on the slave side; the datapath (or a
// bench) drives the hazard inputs from the master side.
//
// Handshake semantics: there is no valid/ready pair here. The memory side
// uses a request/complete pair. mem_req marks an access issued by MEM this
// cycle. mem_ready marks the access completing this cycle. A cycle with
// mem_req=1 and mem_ready=0 freezes the pipeline. The freeze lasts until a
// cycle with mem_ready=1.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             counters_clear;
    logic             pc_enable;
    logic             ifid_enable;
    logic             ifid_flush;
    logic             idex_enable;
    logic             idex_bubble;
    logic             exmem_enable;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready, counters_clear,
        input  pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
               exmem_enable, ctrl_state, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready, counters_clear,
        output pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
               exmem_enable, ctrl_state, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage core. The controller drives the
// enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM
// registers. It inserts load-use bubbles and applies taken-branch redirects.
// It freezes everything while the data memory is busy. It also counts stall
// and flush cycles.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LOAD_STALL_CYCLES - 1);

    state_t           state, ret_state, eff_state, state_nx, ret_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             hazard, mem_stall;
    logic             pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    // Next-state and control decode. A resume cycle out of MEM_WAIT behaves
    // exactly like the state that was interrupted.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_fl   = 1'b0;
        idex_en   = 1'b1;
        idex_bub  = 1'b0;
        exmem_en  = 1'b1;
        state_nx  = state;
        ret_nx    = ret_state;
        cnt_nx    = cnt;
        eff_state = (state == MEM_WAIT) ? ret_state : state;
        if (state == MEM_WAIT && !bus.mem_ready) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else begin
            state_nx = eff_state;
            unique case (eff_state)
                RUN: begin
                    if (mem_stall) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        ret_nx   = RUN;
                        state_nx = MEM_WAIT;
                    end else if (bus.ex_branch_taken) begin
                        ifid_fl  = 1'b1;
                        idex_bub = 1'b1;
                    end else if (hazard) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_bub = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_nx   = CNT_LOAD;
                            state_nx = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    // EX holds a bubble here, so redirects and new hazards
                    // cannot originate from it.
                    if (mem_stall) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        ret_nx   = LOAD_STALL;
                        state_nx = MEM_WAIT;
                    end else begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_bub = 1'b1;
                        if (cnt == 4'd1) begin
                            cnt_nx   = 4'd0;
                            state_nx = RUN;
                        end else begin
                            cnt_nx = cnt - 4'd1;
                        end
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // Reset holds the whole pipeline still without injecting NOPs.
    assign bus.pc_enable    = pc_en && !reset;
    assign bus.ifid_enable  = ifid_en && !reset;
    assign bus.ifid_flush   = ifid_fl && !reset;
    assign bus.idex_enable  = idex_en && !reset;
    assign bus.idex_bubble  = idex_bub && !reset;
    assign bus.exmem_enable = exmem_en && !reset;
    assign bus.ctrl_state   = state;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;

    // State, bubble counter and saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            cnt       <= cnt_nx;
            if (bus.counters_clear) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
                if (ifid_fl && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances share one stimulus stream.
// Instance a uses 3 load-stall cycles and 16-bit counters. Instance b uses
// 1 load-stall cycle and 4-bit counters. A bubble-debt model predicts every
// output of both instances.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic mem_req, mem_ready, counters_clear;
    logic chk_on = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.id_rs1 = id_rs1;           assign if_b.id_rs1 = id_rs1;
    assign if_a.id_rs2 = id_rs2;           assign if_b.id_rs2 = id_rs2;
    assign if_a.id_uses_rs1 = id_uses_rs1; assign if_b.id_uses_rs1 = id_uses_rs1;
    assign if_a.id_uses_rs2 = id_uses_rs2; assign if_b.id_uses_rs2 = id_uses_rs2;
    assign if_a.ex_rd = ex_rd;             assign if_b.ex_rd = ex_rd;
    assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.ex_branch_taken = ex_branch_taken;
    assign if_b.ex_branch_taken = ex_branch_taken;
    assign if_a.mem_req = mem_req;         assign if_b.mem_req = mem_req;
    assign if_a.mem_ready = mem_ready;     assign if_b.mem_ready = mem_ready;
    assign if_a.counters_clear = counters_clear;
    assign if_b.counters_clear = counters_clear;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a));
    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b));

    // Model: rem = bubbles still owed, frozen = waiting on memory.
    typedef struct packed {
        int   rem;
        logic frozen;
        int   stall;
        int   flush;
    } mdl_t;

    mdl_t ma, mb;

    // ctl packing: {pc, ifid, flush, idex, bubble, exmem}
    function automatic void mdl_eval(input int lsc, input int cmax, input mdl_t m,
                                     output logic [5:0] ctl, output logic [1:0] st,
                                     output mdl_t nx);
        logic hz;
        hz = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        nx = m;
        ctl = 6'b110101;
        st = m.frozen ? 2'd2 : (m.rem > 0 ? 2'd1 : 2'd0);
        if (m.frozen && !mem_ready) begin
            ctl = 6'b000000;
        end else begin
            nx.frozen = 1'b0;
            if (mem_req && !mem_ready) begin
                ctl = 6'b000000;
                nx.frozen = 1'b1;
            end else if (m.rem > 0) begin
                ctl = 6'b000111;
                nx.rem = m.rem - 1;
            end else if (ex_branch_taken) begin
                ctl = 6'b111111;
            end else if (hz) begin
                ctl = 6'b000111;
                nx.rem = lsc - 1;
            end
        end
        if (reset) begin
            ctl = 6'b000000;
            st = 2'd0;
        end
        if (counters_clear) begin
            nx.stall = 0;
            nx.flush = 0;
        end else begin
            if (!ctl[5] && !reset && m.stall < cmax) nx.stall = m.stall + 1;
            if (ctl[3] && m.flush < cmax) nx.flush = m.flush + 1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advance.
    logic [5:0] u_c;
    logic [1:0] u_s;
    mdl_t u_na, u_nb;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            mdl_eval(3, 65535, ma, u_c, u_s, u_na);
            mdl_eval(1, 15, mb, u_c, u_s, u_nb);
            ma <= u_na;
            mb <= u_nb;
        end
    end

    // Per-cycle comparison of both instances against the model.
    logic [5:0] c_ctl;
    logic [1:0] c_st;
    mdl_t c_nx;
    always @(negedge clk) begin
        if (chk_on) begin
            mdl_eval(3, 65535, ma, c_ctl, c_st, c_nx);
            chk("a_ctl", int'({if_a.pc_enable, if_a.ifid_enable, if_a.ifid_flush,
                               if_a.idex_enable, if_a.idex_bubble, if_a.exmem_enable}),
                int'(c_ctl));
            chk("a_state", int'(if_a.ctrl_state), int'(c_st));
            chk("a_stall", int'(if_a.stall_count), ma.stall);
            chk("a_flush", int'(if_a.flush_count), ma.flush);
            mdl_eval(1, 15, mb, c_ctl, c_st, c_nx);
            chk("b_ctl", int'({if_b.pc_enable, if_b.ifid_enable, if_b.ifid_flush,
                               if_b.idex_enable, if_b.idex_bubble, if_b.exmem_enable}),
                int'(c_ctl));
            chk("b_state", int'(if_b.ctrl_state), int'(c_st));
            chk("b_stall", int'(if_b.stall_count), mb.stall);
            chk("b_flush", int'(if_b.flush_count), mb.flush);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0; counters_clear = 0;
    endtask

    task automatic load_use_rs2();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    endtask

    // Directed stimulus with literal expectations.
    initial begin
        idle_inputs();
        #2 reset = 1'b1;
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_pc", int'(if_a.pc_enable), 0);
        chk("rst_exmem", int'(if_b.exmem_enable), 0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        // Load-use on rs2: b stalls once, a stalls three times.
        load_use_rs2();
        @(negedge clk);
        chk("lu_a_state0", int'(if_a.ctrl_state), 0);
        chk("lu_b_pc", int'(if_b.pc_enable), 0);
        chk("lu_b_bub", int'(if_b.idex_bubble), 1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("lu_a_state1", int'(if_a.ctrl_state), 1);
        chk("lu_b_pc_resume", int'(if_b.pc_enable), 1);
        cyc();
        @(negedge clk);
        chk("lu_a_state2", int'(if_a.ctrl_state), 1);
        chk("lu_a_bub2", int'(if_a.idex_bubble), 1);
        cyc();
        @(negedge clk);
        chk("lu_a_state3", int'(if_a.ctrl_state), 0);
        chk("lu_a_pc3", int'(if_a.pc_enable), 1);
        chk("lu_a_stall", int'(if_a.stall_count), 3);
        chk("lu_b_stall", int'(if_b.stall_count), 1);
        // Load into x0 never creates a hazard.
        cyc();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        @(negedge clk);
        chk("x0_a_pc", int'(if_a.pc_enable), 1);
        chk("x0_b_pc", int'(if_b.pc_enable), 1);
        // Branch wins over a coincident hazard.
        cyc();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
        @(negedge clk);
        chk("br_a_flush", int'(if_a.ifid_flush), 1);
        chk("br_a_bub", int'(if_a.idex_bubble), 1);
        chk("br_a_pc", int'(if_a.pc_enable), 1);
        chk("br_b_flush", int'(if_b.ifid_flush), 1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("br_a_fcnt", int'(if_a.flush_count), 1);
        chk("br_a_stall", int'(if_a.stall_count), 3);
        chk("br_b_stall", int'(if_b.stall_count), 1);
        // Memory wait of 4 cycles in the middle of a load stall.
        cyc();
        load_use_rs2();
        cyc();
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        @(negedge clk);
        chk("mw_a_state_ls", int'(if_a.ctrl_state), 1);
        chk("mw_a_exmem", int'(if_a.exmem_enable), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("mw_a_state_wait", int'(if_a.ctrl_state), 2);
            chk("mw_a_ifid", int'(if_a.ifid_enable), 0);
        end
        cyc();
        mem_ready = 1;
        @(negedge clk);
        chk("mw_a_resume_bub", int'(if_a.idex_bubble), 1);
        chk("mw_a_resume_exmem", int'(if_a.exmem_enable), 1);
        chk("mw_a_resume_pc", int'(if_a.pc_enable), 0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("mw_a_state_last", int'(if_a.ctrl_state), 1);
        cyc();
        @(negedge clk);
        chk("mw_a_state_run", int'(if_a.ctrl_state), 0);
        chk("mw_a_stall", int'(if_a.stall_count), 10);
        chk("mw_b_stall", int'(if_b.stall_count), 6);
        // A branch held through a memory freeze is applied on resume.
        cyc();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        @(negedge clk);
        chk("hb_a_flush_frozen", int'(if_a.ifid_flush), 0);
        cyc();
        @(negedge clk);
        chk("hb_a_state", int'(if_a.ctrl_state), 2);
        cyc();
        mem_ready = 1;
        @(negedge clk);
        chk("hb_a_flush", int'(if_a.ifid_flush), 1);
        chk("hb_a_pc", int'(if_a.pc_enable), 1);
        chk("hb_b_flush", int'(if_b.ifid_flush), 1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("hb_a_fcnt", int'(if_a.flush_count), 2);
        chk("hb_a_stall", int'(if_a.stall_count), 12);
        // Long memory wait saturates both stall counters.
        cyc();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 65540; i++) cyc();
        @(negedge clk);
        chk("sat_a", int'(if_a.stall_count), 65535);
        chk("sat_b", int'(if_b.stall_count), 15);
        cyc();
        counters_clear = 1;
        cyc();
        counters_clear = 0;
        @(negedge clk);
        chk("clr_a_stall", int'(if_a.stall_count), 0);
        chk("clr_b_stall", int'(if_b.stall_count), 0);
        chk("clr_a_flush", int'(if_a.flush_count), 0);
        // Reset while in MEM_WAIT returns to RUN at once.
        cyc();
        @(negedge clk);
        chk("rw_a_state_pre", int'(if_a.ctrl_state), 2);
        cyc();
        reset = 1'b1;
        #1;
        chk("rw_a_pc", int'(if_a.pc_enable), 0);
        chk("rw_a_state", int'(if_a.ctrl_state), 0);
        chk("rw_a_stall", int'(if_a.stall_count), 0);
        chk("rw_b_state", int'(if_b.ctrl_state), 0);
        cyc();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rw_a_pc_after", int'(if_a.pc_enable), 1);
        chk("rw_a_exmem_after", int'(if_a.exmem_enable), 1);
        chk("rw_b_ifid_after", int'(if_b.ifid_enable), 1);
        cyc();
        cyc();
        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It generates the enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, applies taken-branch redirects and freezes the pipeline while the data memory is busy. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- LOAD_STALL_CYCLES, default 1: bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX (ID/EX register).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- counters_clear  in  1  synchronous clear of both counters.
- pc_enable  out  1  PC register load enable.
- ifid_enable  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP instead of the fetched word.
- idex_enable  out  1  ID/EX register load enable.
- idex_bubble  out  1  ID/EX loads all-zero control bits (NOP).
- exmem_enable  out  1  EX/MEM and MEM/WB load enable.
- ctrl_state  out  2  current FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- stall_count  out  CNT_W  cycles with pc_enable=0, saturating.
- flush_count  out  CNT_W  cycles with ifid_flush=1, saturating.

## Operation
- **Hazard term.** hazard = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- **Output model.** Outputs are combinational from state, the 4-bit bubble counter cnt and the inputs. Default: all enables 1, ifid_flush=0, idex_bubble=0.
- **RUN state.** Priority is mem stall > redirect > hazard.
  - mem_req & !mem_ready: all enables 0. Save return state RUN. Go to MEM_WAIT.
  - ex_branch_taken: pc_enable=1, ifid_flush=1, idex_bubble=1. A coincident hazard is ignored. Stay in RUN.
  - hazard: pc_enable=0, ifid_enable=0, idex_enable=1, idex_bubble=1. If LOAD_STALL_CYCLES>1, load cnt=LOAD_STALL_CYCLES-1 and go to LOAD_STALL; otherwise stay in RUN.
- **LOAD_STALL state.**
  - Outputs: pc_enable=0, ifid_enable=0, idex_bubble=1.
  - ex_branch_taken and hazard are ignored, because EX holds a bubble.
  - If mem_req & !mem_ready: all enables 0, save return state LOAD_STALL with cnt held, go to MEM_WAIT.
  - Else if cnt==1: go to RUN. Else: cnt decrements.
- **MEM_WAIT state.**
  - While mem_ready=0: all enables 0, no flush or bubble, state held.
  - In the cycle mem_ready=1: outputs and next state are evaluated exactly as the saved return state would evaluate them, including a new stall if mem_req is still pending.
- **Reset.** While reset=1, all enables are forced to 0 and ifid_flush/idex_bubble to 0. State becomes RUN, cnt=0, both counters 0.
- **Counters.**
  - stall_count increments when pc_enable=0 and reset=0.
  - flush_count increments when ifid_flush=1.
  - Both saturate at 2^CNT_W-1.
  - counters_clear has priority over increment; the count is 0 on the next edge.

## Timing
- Control outputs have zero-cycle latency: they are valid in the same cycle as the inputs, before the next clk rising edge.
- A load-use hazard costs exactly LOAD_STALL_CYCLES bubbles. The dependent instruction leaves ID on the edge after the last bubble.
- A taken branch costs 2 cycles: IF/ID flushed and ID/EX bubbled on one edge.
- A memory wait of k cycles (mem_ready low for k cycles) adds exactly k frozen cycles. Pipeline contents and cnt are unchanged across them.
- A branch in EX during a memory freeze is held and applied in the resume cycle.
- Reset asserted mid-stall or mid-wait returns to RUN asynchronously. The first edge after release runs normally.

## Test plan
- Load x5 in EX, ID reads rs2=x5 (id_uses_rs2=1), LOAD_STALL_CYCLES=1 -> one cycle with pc_enable=0, idex_bubble=1; stall_count=1; state stays 0.
- LOAD_STALL_CYCLES=3, same hazard -> 3 consecutive bubble cycles, ctrl_state 0→1→1→0, stall_count=3. Hazard with ex_rd=0 -> no stall.
- ex_branch_taken=1 together with a hazard -> ifid_flush=1, idex_bubble=1, pc_enable=1, flush_count=1, no stall.
- mem_req=1, mem_ready=0 for 4 cycles during LOAD_STALL (cnt=2) -> all enables 0 for 4 cycles, ctrl_state=2. Resume into LOAD_STALL with cnt=2. Total stall_count = bubbles + 4.
- stall_count preset near 0xFFFF with a long memory wait -> counter holds at 0xFFFF. counters_clear=1 -> 0 next edge.
- Assert reset in MEM_WAIT -> all enables 0 immediately, ctrl_state=0, counters 0; after release, enables=1 with no hazard.
